lut_fn_eval: RTL and testbench

A parametrised, registered N-input Boolean function evaluator with a run-time programmable truth table. It generalises the lab 9 fixed 4-input function-with-enable block: width is a parameter, the function is loaded serially, evaluation is handshaked, and the result is registered. It sits between a stimulus/control source and downstream logic. The table is loaded once through a serial configuration port, then the block evaluates `f(W)` on a valid/enable handshake.

---
 rtl/lut_fn_pkg.sv | 24 ++
 rtl/lut_cfg_loader.sv | 113 +++++++++++
 rtl/lut_fn_eval.sv | 104 ++++++++++
 tb/tb_lut_fn_eval.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/lut_fn_pkg.sv
// -----------------------------------------------------------------------------
// lut_fn_pkg
//   Shared definitions for the programmable truth-table function evaluator:
//   the loader state encoding, the truth-table depth helper and the widest
//   supported function input.
// -----------------------------------------------------------------------------
package lut_fn_pkg;

  // Widest function input the evaluator is intended for (table depth 64).
  localparam int N_MAX = 6;

  // Loader / evaluator state.
  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } lut_state_e;

  // Number of truth-table entries for an n-input function.
  function automatic int tt_depth(input int n);
    return 32'sd1 << n;
  endfunction

endpackage : lut_fn_pkg

// File: rtl/lut_cfg_loader.sv
// -----------------------------------------------------------------------------
// lut_cfg_loader
//   Serial truth-table loader. Owns the UNCFG/LOAD/READY state machine, the
//   bit counter and the table register. Bits arrive LSB (index 0) first, one
//   per accepted cfg_valid cycle; cfg_start restarts the load from index 0
//   at any time and wins over a cfg_valid in the same cycle.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   cfg_start  in   begin / restart a table load
//   cfg_valid  in   cfg_bit is valid this cycle
//   cfg_bit    in   next truth-table entry
//   state      out  current (registered) state
//   tbl        out  truth table, bit i = f(i)
//   cfg_busy   out  registered, high while in LOAD
//   cfg_ready  out  registered, high while in READY
// -----------------------------------------------------------------------------
module lut_cfg_loader
  import lut_fn_pkg::*;
#(
  parameter int N = 4,
  localparam int TT_D = tt_depth(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output lut_state_e      state,
  output logic [TT_D-1:0] tbl,
  output logic            cfg_busy,
  output logic            cfg_ready
);

  // One extra bit over the index width; the counter never needs to wrap
  // because LOAD is left when the last index is written.
  localparam int CW = $clog2(TT_D) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TT_D - 1);

  lut_state_e      state_r;
  lut_state_e      state_nxt;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_nxt;
  logic [TT_D-1:0] tbl_r;
  logic [TT_D-1:0] tbl_nxt;
  logic            busy_r;
  logic            ready_r;

  // Next-state, bit-counter and table-write decode.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    tbl_nxt   = tbl_r;
    if (cfg_start) begin
      // Restart: any bit presented alongside cfg_start is dropped.
      state_nxt = LOAD;
      cnt_nxt   = '0;
    end else begin
      case (state_r)
        UNCFG: begin
          state_nxt = UNCFG;
        end
        LOAD: begin
          if (cfg_valid) begin
            tbl_nxt[cnt_r[CW-2:0]] = cfg_bit;
            cnt_nxt                = cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
              state_nxt = READY;
            end else begin
              state_nxt = LOAD;
            end
          end else begin
            state_nxt = LOAD;
          end
        end
        READY: begin
          state_nxt = READY;
        end
        default: begin
          // Unreachable encoding: fall back to the unconfigured state.
          state_nxt = UNCFG;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counter, table and status flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= UNCFG;
      cnt_r   <= '0;
      tbl_r   <= '0;
      busy_r  <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      tbl_r   <= tbl_nxt;
      // Flags are registered from the next state so they track state_r exactly.
      busy_r  <= (state_nxt == LOAD);
      ready_r <= (state_nxt == READY);
    end
  end

  assign state     = state_r;
  assign tbl       = tbl_r;
  assign cfg_busy  = busy_r;
  assign cfg_ready = ready_r;

endmodule : lut_cfg_loader

// File: rtl/lut_fn_eval.sv
// -----------------------------------------------------------------------------
// lut_fn_eval
//   Registered N-input Boolean function evaluator with a serially loaded
//   truth table. A request (in_valid) is answered one cycle later on
//   out_valid/f. Requests made before the table is complete return f=0 and
//   raise the sticky err flag, which only reset or cfg_start clears.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   cfg_start  in   begin / restart a table load
//   cfg_valid  in   cfg_bit is valid this cycle
//   cfg_bit    in   truth-table entry, index order 0..2**N-1
//   cfg_busy   out  high while loading
//   cfg_ready  out  high once the table is complete
//   W          in   function input (unsigned table index)
//   En         in   function enable; f=0 when low
//   in_valid   in   evaluation request
//   f          out  registered result, holds when no request
//   out_valid  out  f is valid this cycle
//   err        out  sticky: request seen while not READY
// -----------------------------------------------------------------------------
module lut_fn_eval
  import lut_fn_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_start,
  input  logic         cfg_valid,
  input  logic         cfg_bit,
  output logic         cfg_busy,
  output logic         cfg_ready,
  input  logic [N-1:0] W,
  input  logic         En,
  input  logic         in_valid,
  output logic         f,
  output logic         out_valid,
  output logic         err
);

  localparam int TT_D = tt_depth(N);

  lut_state_e      state;
  logic [TT_D-1:0] tbl;
  logic            ready_s;
  logic            f_r;
  logic            out_valid_r;
  logic            err_r;

  lut_cfg_loader #(
    .N (N)
  ) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .state     (state),
    .tbl       (tbl),
    .cfg_busy  (cfg_busy),
    .cfg_ready (cfg_ready)
  );

  // Registered state is used, so a request in the same cycle as the last
  // table bit still counts as not ready.
  assign ready_s = (state == READY);

  // Evaluation result and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_r         <= 1'b0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      if (in_valid) begin
        out_valid_r <= 1'b1;
        if (ready_s) begin
          f_r <= En & tbl[W];
        end else begin
          f_r <= 1'b0;
        end
      end else begin
        out_valid_r <= 1'b0;
        f_r         <= f_r;
      end

      // A restart clears the error even if a request arrives alongside it.
      if (cfg_start) begin
        err_r <= 1'b0;
      end else if (in_valid && !ready_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign f         = f_r;
  assign out_valid = out_valid_r;
  assign err       = err_r;

endmodule : lut_fn_eval

// File: tb/tb_lut_fn_eval.sv
// -----------------------------------------------------------------------------
// tb_lut_fn_eval
//   Directed self-checking bench for lut_fn_eval with N=4. Inputs change just
//   after the falling edge; outputs are sampled on the falling edge, half a
//   cycle after the rising edge that produced them.
// -----------------------------------------------------------------------------
module tb_lut_fn_eval;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_start;
  logic         cfg_valid;
  logic         cfg_bit;
  logic         cfg_busy;
  logic         cfg_ready;
  logic [N-1:0] W;
  logic         En;
  logic         in_valid;
  logic         f;
  logic         out_valid;
  logic         err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_tbl;
  logic [3:0]  w_list [5];
  logic        f_list [5];

  always #5 clk = ~clk;

  lut_fn_eval #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_busy  (cfg_busy),
    .cfg_ready (cfg_ready),
    .W         (W),
    .En        (En),
    .in_valid  (in_valid),
    .f         (f),
    .out_valid (out_valid),
    .err       (err)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Feed nbits consecutive table bits val[0..nbits-1], one per cycle.
  task automatic send_bits(input logic [15:0] val, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = val[i];
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    W         = '0;
    En        = 1'b0;
    in_valid  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_f", f, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", cfg_busy, 1'b0);
    check("rst_ready", cfg_ready, 1'b0);
    check("rst_err", err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Request before any load: f=0, out_valid=1, err set and sticky
    in_valid = 1'b1; W = 4'd5; En = 1'b1;
    @(negedge clk);
    check("uncfg_f", f, 1'b0);
    check("uncfg_out_valid", out_valid, 1'b1);
    check("uncfg_err", err, 1'b1);
    W = 4'd3;
    @(negedge clk);
    check("uncfg_err_sticky", err, 1'b1);
    in_valid = 1'b0; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    check("start_clears_err", err, 1'b0);
    check("start_busy", cfg_busy, 1'b1);
    check("start_not_ready", cfg_ready, 1'b0);

    // Load parity table 0x6996 and sweep every W
    send_bits(16'h6996, 16);
    check("par_ready", cfg_ready, 1'b1);
    check("par_busy", cfg_busy, 1'b0);
    exp_tbl = 16'h6996;
    for (int w = 0; w < 16; w++) begin
      in_valid = 1'b1; W = 4'(w); En = 1'b1;
      @(negedge clk);
      check($sformatf("par_f_w%0d", w), f, exp_tbl[w]);
      check($sformatf("par_ov_w%0d", w), out_valid, 1'b1);
    end
    in_valid = 1'b0;
    check("par_err", err, 1'b0);

    // Hold when idle, then En=0 forces 0 without error
    in_valid = 1'b1; W = 4'd7; En = 1'b1;
    @(negedge clk);
    check("w7_f", f, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("idle_out_valid", out_valid, 1'b0);
    check("idle_f_hold", f, 1'b1);
    in_valid = 1'b1; W = 4'd7; En = 1'b0;
    @(negedge clk);
    check("en0_f", f, 1'b0);
    check("en0_out_valid", out_valid, 1'b1);
    check("en0_err", err, 1'b0);
    in_valid = 1'b0;

    // Partial load of ones, restart (with a colliding bit), then load 0x8000
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    send_bits(16'hFFFF, 5);
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    check("restart_busy", cfg_busy, 1'b1);
    send_bits(16'h0000, 7);
    @(negedge clk);
    check("gap_busy", cfg_busy, 1'b1);
    send_bits(16'h0000, 8);
    check("15bits_not_ready", cfg_ready, 1'b0);
    check("15bits_busy", cfg_busy, 1'b1);
    // Last bit together with a request: request is still not-ready
    cfg_valid = 1'b1; cfg_bit = 1'b1; in_valid = 1'b1; W = 4'd15; En = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; cfg_bit = 1'b0;
    check("16bits_ready", cfg_ready, 1'b1);
    check("lastbit_req_err", err, 1'b1);
    check("lastbit_req_f", f, 1'b0);
    check("lastbit_req_ov", out_valid, 1'b1);
    w_list = '{4'd15, 4'd0, 4'd4, 4'd7, 4'd14};
    f_list = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      W = w_list[k];
      @(negedge clk);
      check($sformatf("and_f_w%0d", w_list[k]), f, f_list[k]);
    end
    W = 4'd15;
    @(negedge clk);
    in_valid = 1'b0;
    check("and_f_w15_again", f, 1'b1);
    check("and_err_sticky", err, 1'b1);

    // Reset in the middle of a load takes effect before the next clock
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    send_bits(16'hFFFF, 9);
    cfg_valid = 1'b1; cfg_bit = 1'b1;
    check("midload_busy", cfg_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_f", f, 1'b0);
    check("async_out_valid", out_valid, 1'b0);
    check("async_busy", cfg_busy, 1'b0);
    check("async_ready", cfg_ready, 1'b0);
    check("async_err", err, 1'b0);
    cfg_valid = 1'b0; cfg_bit = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", cfg_busy, 1'b0);
    in_valid = 1'b1; W = 4'd3; En = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_f", f, 1'b0);
    check("post_rst_err", err, 1'b1);
    check("post_rst_ready", cfg_ready, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_lut_fn_eval
